// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end sharing one registered ALU
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/reqN_ready      command handshake per requester (ready pulses in grant cycle)
//   reqN_a, reqN_b, reqN_op    operands and 4-bit opcode per requester
//   respN_valid/respN_ready    result handshake per requester
//   resp_out, resp_of/un/err/zero  shared registered result and flags
//   busy                       high whenever the FSM is not IDLE
module alu_arbiter #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic            req1_valid,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    input  logic [3:0]      req0_op,
    input  logic [3:0]      req1_op,
    output logic            resp0_valid,
    output logic            resp1_valid,
    input  logic            resp0_ready,
    input  logic            resp1_ready,
    output logic [SIZE-1:0] resp_out,
    output logic            resp_of,
    output logic            resp_un,
    output logic            resp_err,
    output logic            resp_zero,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t          state_q;
    logic            prio_q;
    logic            gnt_q;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic [3:0]      op_q;
    logic [SIZE-1:0] out_q;
    logic            of_q;
    logic            un_q;
    logic            err_q;
    logic            zero_q;
    logic            any_req;
    logic            gnt_d;
    logic [SIZE:0]   sum;
    logic [SIZE-1:0] alu_out;
    logic            alu_of;
    logic            alu_un;
    logic            alu_err;
    logic            alu_cmp;
    assign any_req = req0_valid | req1_valid;
    // prio_q names the requester that wins a tie
    assign gnt_d = (req0_valid && req1_valid) ? prio_q : req1_valid;
    // ready is combinational so the handshake completes in the IDLE grant cycle;
    // gating with rst_n keeps it low while reset is held
    assign req0_ready = rst_n && state_q == IDLE && any_req && !gnt_d;
    assign req1_ready = rst_n && state_q == IDLE && any_req && gnt_d;
    assign resp0_valid = state_q == RESP && !gnt_q;
    assign resp1_valid = state_q == RESP && gnt_q;
    assign busy = state_q != IDLE;
    assign resp_out = out_q;
    assign resp_of = of_q;
    assign resp_un = un_q;
    assign resp_err = err_q;
    assign resp_zero = zero_q;
    assign sum = {1'b0, a_q} + {1'b0, b_q};
    always_comb begin
        alu_out = '0;
        alu_of  = 1'b0;
        alu_un  = 1'b0;
        alu_err = 1'b0;
        alu_cmp = 1'b0;
        case (op_q)
            4'd0: begin
                alu_out = sum[SIZE-1:0];
                alu_of  = sum[SIZE];
            end
            4'd1: begin
                alu_out = a_q - b_q;
                alu_un  = a_q < b_q;
            end
            // logical shifts by SIZE or more already yield zero
            4'd2: alu_out = a_q << b_q;
            4'd3: alu_out = a_q >> b_q;
            4'd4: begin
                alu_out = SIZE'(a_q == b_q);
                alu_cmp = 1'b1;
            end
            4'd5: begin
                alu_out = SIZE'(a_q > b_q);
                alu_cmp = 1'b1;
            end
            4'd6: begin
                alu_out = SIZE'(a_q < b_q);
                alu_cmp = 1'b1;
            end
            default: alu_err = 1'b1;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            out_q   <= '0;
            of_q    <= 1'b0;
            un_q    <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (any_req) begin
                    gnt_q   <= gnt_d;
                    prio_q  <= !gnt_d;
                    a_q     <= gnt_d ? req1_a : req0_a;
                    b_q     <= gnt_d ? req1_b : req0_b;
                    op_q    <= gnt_d ? req1_op : req0_op;
                    state_q <= EXEC;
                end
                EXEC: begin
                    out_q   <= alu_out;
                    of_q    <= alu_of;
                    un_q    <= alu_un;
                    err_q   <= alu_err;
                    zero_q  <= alu_cmp && alu_out == '0;
                    state_q <= RESP;
                end
                RESP: if (gnt_q ? resp1_ready : resp0_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table, random and corner-sequence checks for alu_arbiter
module tb_alu_arbiter;
    localparam int W = 8;
    localparam int M = 1 << W;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]   req0_op = '0, req1_op = '0;
    logic         resp0_valid, resp1_valid;
    logic         resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic [W-1:0] resp_out;
    logic         resp_of, resp_un, resp_err, resp_zero, busy;
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    alu_arbiter #(.SIZE(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_out(resp_out), .resp_of(resp_of), .resp_un(resp_un),
        .resp_err(resp_err), .resp_zero(resp_zero), .busy(busy)
    );
    typedef struct {
        bit id;
        int a, b, op;
        int out;
        bit of, un, err, zero;
    } vec_t;
    vec_t vecs[$];
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Reference behaviour from the opcode rules using plain integer arithmetic
    function automatic vec_t model(input bit id, input int a, input int b, input int op);
        vec_t v;
        v = '{id: id, a: a, b: b, op: op, out: 0, of: 0, un: 0, err: 0, zero: 0};
        case (op)
            0: begin v.out = (a + b) % M; v.of = (a + b) >= M; end
            1: begin v.out = (a - b + M) % M; v.un = a < b; end
            2: v.out = (b >= W) ? 0 : (a * (1 << b)) % M;
            3: v.out = (b >= W) ? 0 : a / (1 << b);
            4: begin v.out = (a == b) ? 1 : 0; v.zero = v.out == 0; end
            5: begin v.out = (a > b) ? 1 : 0; v.zero = v.out == 0; end
            6: begin v.out = (a < b) ? 1 : 0; v.zero = v.out == 0; end
            default: v.err = 1;
        endcase
        return v;
    endfunction
    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask
    // One full transaction with resp_ready high; starts and ends in IDLE
    task automatic run_op(input vec_t v);
        int n;
        if (v.id) begin
            req1_valid = 1; req1_a = W'(v.a); req1_b = W'(v.b); req1_op = 4'(v.op);
        end else begin
            req0_valid = 1; req0_a = W'(v.a); req0_b = W'(v.b); req0_op = 4'(v.op);
        end
        #1;
        n = 0;
        while (!(v.id ? req1_ready : req0_ready) && n < 20) begin
            tick();
            n++;
        end
        check("accept", int'(v.id ? req1_ready : req0_ready), 1);
        tick();
        req0_valid = 0;
        req1_valid = 0;
        check("exec_busy", int'(busy), 1);
        check("exec_novalid", int'(resp0_valid | resp1_valid), 0);
        tick();
        check("resp_valid_own", int'(v.id ? resp1_valid : resp0_valid), 1);
        check("resp_valid_other", int'(v.id ? resp0_valid : resp1_valid), 0);
        check("resp_out", int'(resp_out), v.out);
        check("resp_flags", int'({resp_of, resp_un, resp_err, resp_zero}),
              int'({v.of, v.un, v.err, v.zero}));
        tick();
        check("back_idle", int'(busy), 0);
    endtask
    initial begin
        vecs.push_back('{0, 200, 100, 0, 44, 1, 0, 0, 0});
        vecs.push_back('{1, 3, 5, 1, 254, 0, 1, 0, 0});
        vecs.push_back('{0, 7, 9, 4, 0, 0, 0, 0, 1});
        vecs.push_back('{1, 7, 9, 9, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 9, 9, 4, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 9, 7, 5, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 9, 7, 6, 0, 0, 0, 0, 1});
        vecs.push_back('{1, 1, 7, 2, 128, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 8, 2, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 255, 8, 3, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 128, 7, 3, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 5, 5, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 255, 1, 0, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 255, 255, 15, 0, 0, 0, 1, 0});
        // reset state, with a request pending while reset is held
        req0_valid = 1;
        #12;
        check("rst_ready0", int'(req0_ready), 0);
        check("rst_outputs", int'({resp0_valid, resp1_valid, resp_of, resp_un, resp_err, resp_zero, busy}), 0);
        check("rst_out", int'(resp_out), 0);
        req0_valid = 0;
        #1;
        rst_n = 1;
        tick();
        foreach (vecs[i]) run_op(vecs[i]);
        for (int i = 0; i < 40; i++) begin
            bit id;
            int a, b, op;
            id = 1'($urandom_range(0, 1));
            a = $urandom_range(0, M - 1);
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : $urandom_range(0, M - 1);
            op = $urandom_range(0, 15);
            run_op(model(id, a, b, op));
        end
        // round robin with both requesters always valid
        do_reset();
        req0_valid = 1; req1_valid = 1;
        req0_a = 1; req0_b = 2; req0_op = 0;
        req1_a = 9; req1_b = 4; req1_op = 1;
        #1;
        for (int k = 0; k < 12; k++) begin
            check("rr_ready0", int'(req0_ready), int'(k % 3 == 0 && (k / 3) % 2 == 0));
            check("rr_ready1", int'(req1_ready), int'(k % 3 == 0 && (k / 3) % 2 == 1));
            check("rr_resp0", int'(resp0_valid), int'(k % 3 == 2 && (k / 3) % 2 == 0));
            check("rr_resp1", int'(resp1_valid), int'(k % 3 == 2 && (k / 3) % 2 == 1));
            if (k % 3 == 2) check("rr_out", int'(resp_out), ((k / 3) % 2 == 0) ? 3 : 5);
            if (k == 11) begin req0_valid = 0; req1_valid = 0; end
            tick();
        end
        // response backpressure while the other requester waits
        do_reset();
        resp0_ready = 0;
        req0_valid = 1; req0_a = 200; req0_b = 100; req0_op = 0;
        req1_valid = 1; req1_a = 3; req1_b = 5; req1_op = 1;
        #1;
        check("bp_grant0", int'(req0_ready), 1);
        check("bp_nogrant1", int'(req1_ready), 0);
        tick();
        req0_valid = 0;
        check("bp_exec_ready1", int'(req1_ready), 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_resp0_held", int'(resp0_valid), 1);
            check("bp_resp1_low", int'(resp1_valid), 0);
            check("bp_out_stable", int'(resp_out), 44);
            check("bp_of_stable", int'(resp_of), 1);
            check("bp_ready1_low", int'(req1_ready), 0);
            if (k < 4) tick();
        end
        resp0_ready = 1;
        tick();
        check("bp_release", int'(resp0_valid), 0);
        check("bp_grant1", int'(req1_ready), 1);
        tick();
        req1_valid = 0;
        tick();
        check("bp_resp1", int'(resp1_valid), 1);
        check("bp_out1", int'(resp_out), 254);
        check("bp_un1", int'(resp_un), 1);
        tick();
        // reset during EXEC discards the operation
        req0_valid = 1; req0_a = 200; req0_b = 100; req0_op = 0;
        #1;
        check("mid_grant", int'(req0_ready), 1);
        tick();
        req0_valid = 0;
        check("mid_exec", int'(busy), 1);
        rst_n = 0;
        #1;
        check("mid_rst_out", int'(resp_out), 0);
        check("mid_rst_flags", int'({resp0_valid, resp1_valid, resp_of, resp_un, resp_err, resp_zero, busy}), 0);
        check("mid_rst_ready", int'({req0_ready, req1_ready}), 0);
        #2;
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_idle", int'({resp0_valid, resp1_valid, busy}), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
